// File: rtl/qc_circulant_unshifter.sv
// qc_circulant_unshifter
// Multi-cycle left rotator that undoes a QC-LDPC circulant shift. The low Z
// bits of a MAXZ-bit block are rotated left by the shift amount. The shift is
// resolved BITS_PER_CYCLE bits per cycle as power-of-two partial rotations.
// The result is held in an output register until downstream accepts it.
module qc_circulant_unshifter #(
   parameter int MAXZ           = 81,
   parameter int BITS_PER_CYCLE = 2
) (
   input  logic                     CLK,
   input  logic                     rst,
   input  logic                     s_valid,
   output logic                     s_ready,
   input  logic [MAXZ-1:0]          s_data,
   input  logic [$clog2(MAXZ)-1:0]  s_shift,
   input  logic [$clog2(MAXZ):0]    s_z,
   output logic                     m_valid,
   input  logic                     m_ready,
   output logic [MAXZ-1:0]          m_data,
   output logic                     m_err
);

   localparam int SW    = $clog2(MAXZ);
   localparam int NSTEP = (SW + BITS_PER_CYCLE - 1) / BITS_PER_CYCLE;
   localparam int STW   = (NSTEP > 1) ? $clog2(NSTEP) : 1;
   localparam int PADW  = NSTEP * BITS_PER_CYCLE;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_ROT  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t             state_q,   state_d;
   logic               ready_q,   ready_d;
   logic [MAXZ-1:0]    data_q,    data_d;
   logic [SW-1:0]      shift_q,   shift_d;
   logic [SW:0]        z_q,       z_d;
   logic               err_q,     err_d;
   logic [STW-1:0]     step_q,    step_d;
   logic               m_valid_q, m_valid_d;
   logic [MAXZ-1:0]    m_data_q,  m_data_d;
   logic               m_err_q,   m_err_d;

   logic [PADW-1:0]           shift_pad_s;
   logic [BITS_PER_CYCLE-1:0] chunk_s;
   logic [MAXZ-1:0]           mask_s;
   logic [MAXZ-1:0]           rot_s;
   logic                      accept_s;
   logic                      cmd_err_s;

   // Mask of the low z bits; z=0 gives no bits, z>MAXZ gives every bit.
   function automatic logic [MAXZ-1:0] z_mask(input logic [SW:0] z);
      logic [MAXZ-1:0] m;
      m = '0;
      for (int k = 0; k < MAXZ; k++) begin
         m[k] = ((SW+1)'(k) < z);
      end
      return m;
   endfunction

   // Left rotation of the low z bits by n, valid for 0 < n < z.
   function automatic logic [MAXZ-1:0] rotl_z(input logic [MAXZ-1:0] x,
                                              input logic [SW:0]     n,
                                              input logic [SW:0]     z,
                                              input logic [MAXZ-1:0] mask);
      return ((x << n) | (x >> (z - n))) & mask;
   endfunction

   assign accept_s  = s_valid & ready_q;
   assign cmd_err_s = (s_z == '0) | (s_z > (SW+1)'(MAXZ)) | ({1'b0, s_shift} >= s_z);

   // Apply this step's slice of shift bits as a chain of 2^k rotations.
   always_comb begin
      shift_pad_s = PADW'(shift_q);
      chunk_s     = BITS_PER_CYCLE'(shift_pad_s >> (int'(step_q) * BITS_PER_CYCLE));
      mask_s      = z_mask(z_q);
      rot_s       = data_q;
      for (int j = 0; j < BITS_PER_CYCLE; j++) begin
         if (chunk_s[j] && !err_q) begin
            rot_s = rotl_z(rot_s, (SW+1)'(1) << (int'(step_q) * BITS_PER_CYCLE + j),
                           z_q, mask_s);
         end else begin
            rot_s = rot_s;
         end
      end
   end

   // Next-state and datapath update for the IDLE/ROT/DONE sequence.
   always_comb begin
      state_d   = state_q;
      data_d    = data_q;
      shift_d   = shift_q;
      z_d       = z_q;
      err_d     = err_q;
      step_d    = step_q;
      m_valid_d = m_valid_q;
      m_data_d  = m_data_q;
      m_err_d   = m_err_q;
      case (state_q)
         ST_IDLE: begin
            if (accept_s) begin
               state_d = ST_ROT;
               data_d  = s_data & z_mask(s_z);
               shift_d = s_shift;
               z_d     = s_z;
               err_d   = cmd_err_s;
               step_d  = '0;
            end else begin
               state_d = ST_IDLE;
            end
         end
         ST_ROT: begin
            data_d = rot_s;
            if (step_q == STW'(NSTEP - 1)) begin
               state_d   = ST_DONE;
               step_d    = '0;
               m_valid_d = 1'b1;
               m_data_d  = rot_s;
               m_err_d   = err_q;
            end else begin
               step_d = step_q + STW'(1);
            end
         end
         ST_DONE: begin
            if (m_ready) begin
               state_d   = ST_IDLE;
               m_valid_d = 1'b0;
            end else begin
               state_d = ST_DONE;
            end
         end
         default: begin
            state_d   = ST_IDLE;
            m_valid_d = 1'b0;
         end
      endcase
      ready_d = (state_d == ST_IDLE);
   end

   // State and datapath registers with synchronous reset.
   always_ff @(posedge CLK) begin
      if (rst) begin
         state_q   <= ST_IDLE;
         ready_q   <= 1'b0;
         data_q    <= '0;
         shift_q   <= '0;
         z_q       <= '0;
         err_q     <= 1'b0;
         step_q    <= '0;
         m_valid_q <= 1'b0;
         m_data_q  <= '0;
         m_err_q   <= 1'b0;
      end else begin
         state_q   <= state_d;
         ready_q   <= ready_d;
         data_q    <= data_d;
         shift_q   <= shift_d;
         z_q       <= z_d;
         err_q     <= err_d;
         step_q    <= step_d;
         m_valid_q <= m_valid_d;
         m_data_q  <= m_data_d;
         m_err_q   <= m_err_d;
      end
   end

   assign s_ready = ready_q;
   assign m_valid = m_valid_q;
   assign m_data  = m_data_q;
   assign m_err   = m_err_q;

endmodule
